// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between NUM_REQ
// writeback sources; the winner is registered and presented one cycle after acceptance.
module writeback_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*AW-1:0]   req_addr,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic                    destinationEnable,
  output logic [AW-1:0]           writeAddress,
  output logic [XLEN-1:0]         writeData,
  output logic [IW-1:0]           grant_id,
  output logic [IW-1:0]           dbg_ptr
);

  // Handshake: a request transfers in the cycle where req_valid[i] && req_ready[i];
  // a requester holds valid/addr/data stable until it sees ready.
  logic [IW-1:0]      ptr;
  logic [2*NUM_REQ-1:0] rot;
  logic               found;
  logic [IW-1:0]      win;
  logic [IW-1:0]      next_ptr;
  logic               grant;
  logic [AW-1:0]      sel_addr;
  logic [XLEN-1:0]    sel_data;

  assign dbg_ptr = ptr;

  // Rotate the valid vector so bit 0 is the requester at the priority pointer.
  always_comb begin
    rot   = {req_valid, req_valid} >> ptr;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        if (int'(ptr) + k >= NUM_REQ) win = IW'(int'(ptr) + k - NUM_REQ);
        else                          win = IW'(int'(ptr) + k);
      end
    end
  end

  always_comb begin
    if (int'(win) + 1 >= NUM_REQ) next_ptr = '0;
    else                          next_ptr = IW'(int'(win) + 1);
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == win) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  assign grant = found && !stall && !reset;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant && (IW'(i) == win)) req_ready[i] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr               <= '0;
      destinationEnable <= 1'b0;
      writeAddress      <= '0;
      writeData         <= '0;
      grant_id          <= '0;
    end else if (grant) begin
      ptr               <= next_ptr;
      // x0 writes are consumed but never strobe the register file
      destinationEnable <= (sel_addr != '0);
      writeAddress      <= sel_addr;
      writeData         <= sel_data;
      grant_id          <= win;
    end else begin
      destinationEnable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter against a round-robin reference
// model, with a scoreboard of expected register-file writes.
module tb_writeback_arbiter;
  localparam int NUM_REQ = 2;
  localparam int XLEN    = 32;
  localparam int AW      = 5;

  logic              clock;
  logic              reset;
  logic              stall;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*AW-1:0]   req_addr;
  logic [2*XLEN-1:0] req_data;
  logic              destinationEnable;
  logic [AW-1:0]     writeAddress;
  logic [XLEN-1:0]   writeData;
  logic [0:0]        grant_id;
  logic [0:0]        dbg_ptr;

  writeback_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .AW(AW)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .destinationEnable(destinationEnable), .writeAddress(writeAddress),
    .writeData(writeData), .grant_id(grant_id), .dbg_ptr(dbg_ptr)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // reference model state
  int              m_ptr;
  logic            m_de;
  logic [AW-1:0]   m_wa;
  logic [XLEN-1:0] m_wd;
  int              m_gid;
  int              m_last_grant;
  logic [XLEN-1:0] m_rf  [32];
  logic [XLEN-1:0] dut_rf[32];
  logic [37:0]     exp_q[$];

  // driver: one clock cycle with the given inputs; checks happen on the falling edge
  task automatic cycle(input logic rst, input logic st, input logic [1:0] v,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1);
    int w;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic [1:0]      exp_ready;
    logic [37:0]     ent;
    reset = rst; stall = st; req_valid = v;
    req_addr = {a1, a0}; req_data = {d1, d0};
    @(negedge clock);
    w = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (m_ptr + k) % NUM_REQ;
      if (w < 0 && v[i]) w = i;
    end
    if (rst || st) w = -1;
    exp_ready = (w < 0) ? 2'b00 : 2'(1 << w);
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("dest_en", 64'(destinationEnable), 64'(m_de));
    check("waddr", 64'(writeAddress), 64'(m_wa));
    check("wdata", 64'(writeData), 64'(m_wd));
    check("grant_id", 64'(grant_id), 64'(m_gid));
    check("ptr", 64'(dbg_ptr), 64'(m_ptr));
    if (destinationEnable === 1'b1) begin
      dut_rf[writeAddress] = writeData;
      if (exp_q.size() == 0) check("spurious_write", 64'(1), 64'(0));
      else begin
        ent = exp_q.pop_front();
        check("sb_write", {26'b0, grant_id, writeAddress, writeData}, {26'b0, ent});
      end
    end
    m_last_grant = w;
    if (rst) begin
      m_ptr = 0; m_de = 0; m_wa = '0; m_wd = '0; m_gid = 0;
    end else if (w >= 0) begin
      wa = (w == 0) ? a0 : a1;
      wd = (w == 0) ? d0 : d1;
      m_de = (wa != 0); m_wa = wa; m_wd = wd; m_gid = w;
      m_ptr = (w + 1) % NUM_REQ;
      if (wa != 0) begin
        exp_q.push_back({1'(w), wa, wd});
        m_rf[wa] = wd;
      end
    end else begin
      m_de = 0;
    end
    @(posedge clock);
    #1;
  endtask

  logic            hv [2];
  logic [AW-1:0]   ha [2];
  logic [XLEN-1:0] hd [2];

  initial begin
    for (int i = 0; i < 32; i++) begin m_rf[i] = '0; dut_rf[i] = '0; end
    reset = 1'b1; stall = 1'b0; req_valid = 2'b11; req_addr = '0; req_data = '0;
    @(posedge clock); #1;
    m_ptr = 0; m_de = 0; m_wa = '0; m_wd = '0; m_gid = 0;

    // reset holds ready low even with both valid
    for (int c = 0; c < 3; c++) cycle(1, 0, 2'b11, 5'd3, 5'd4, 32'h1, 32'h2);
    cycle(0, 0, 2'b00, 0, 0, 0, 0);
    // single requester
    cycle(0, 0, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0);
    cycle(0, 0, 2'b00, 0, 0, 0, 0);
    check("x5_after_single", 64'(dut_rf[5]), 64'h0000_0000_DEAD_BEEF);
    // alternating grants, no bubbles
    for (int c = 0; c < 6; c++) cycle(0, 0, 2'b11, 5'd1, 5'd2, 32'hA, 32'hB);
    // x0 request consumed without strobe
    cycle(0, 0, 2'b10, 5'd0, 5'd0, 32'h0, 32'h1234);
    cycle(0, 0, 2'b00, 0, 0, 0, 0);
    // stall with both valid, then resume
    cycle(0, 0, 2'b11, 5'd9, 5'd10, 32'h90, 32'hA0);
    cycle(0, 1, 2'b11, 5'd9, 5'd10, 32'h91, 32'hA0);
    cycle(0, 1, 2'b11, 5'd9, 5'd10, 32'h91, 32'hA0);
    cycle(0, 0, 2'b11, 5'd9, 5'd10, 32'h91, 32'hA0);
    cycle(0, 0, 2'b01, 5'd9, 5'd10, 32'h92, 32'hA0);
    // same-address conflict: later grant wins
    cycle(0, 0, 2'b11, 5'd7, 5'd7, 32'd11, 32'd22);
    cycle(0, 0, 2'b10, 5'd7, 5'd7, 32'd11, 32'd22);
    cycle(0, 0, 2'b00, 0, 0, 0, 0);
    check("x7_final", 64'(dut_rf[7]), 64'd22);
    // reset arriving while a write is on the port
    cycle(0, 0, 2'b01, 5'd12, 5'd0, 32'hC0FFEE, 32'h0);
    cycle(1, 0, 2'b11, 5'd13, 5'd14, 32'h1, 32'h2);
    cycle(0, 0, 2'b00, 0, 0, 0, 0);
    check("x12_after_reset", 64'(dut_rf[12]), 64'h0000_0000_00C0_FFEE);

    // randomized traffic obeying the requester contract
    for (int i = 0; i < 2; i++) begin hv[i] = 0; ha[i] = '0; hd[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      logic r, s;
      for (int i = 0; i < 2; i++) begin
        if (!hv[i] && $urandom_range(0, 1) == 1) begin
          hv[i] = 1;
          ha[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
          hd[i] = $urandom;
        end
      end
      r = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 4) == 0);
      cycle(r, s, {hv[1], hv[0]}, ha[0], ha[1], hd[0], hd[1]);
      if (m_last_grant >= 0) hv[m_last_grant] = 0;
    end
    cycle(0, 0, 2'b00, 0, 0, 0, 0);
    cycle(0, 0, 2'b00, 0, 0, 0, 0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    for (int i = 1; i < 32; i++) check("rf_match", 64'(dut_rf[i]), 64'(m_rf[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
